// File: rtl/adc_acq_sched_pkg.sv
// Shared definitions for the ADC acquisition scheduler: state encoding and
// the default timing/width parameters.
package adc_acq_sched_pkg;

   localparam int RST_CYCLES_DEF   = 8;
   localparam int GUARD_CYCLES_DEF = 4;
   localparam int CNT_W_DEF        = 16;

   // FSM state encoding (legacy-compatible constants)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ADC_RST = 2'd1;
   localparam logic [1:0] ST_ACQ     = 2'd2;
   localparam logic [1:0] ST_GUARD   = 2'd3;

   // Larger of two integers, used to size the shared duration counter
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adc_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that was not served
// last wins; after reset requester 0 has priority.
module adc_rr_arb2
   import adc_acq_sched_pkg::*;
(
   input  logic       clk_200MHz_i,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt_sel,
   output logic       any_req
);

   // 1: requester 1 was served last, so requester 0 wins the next tie
   logic last_gnt;

   assign any_req = |req;

   // Pick the winner for the current request pattern
   always_comb begin
      gnt_sel = 2'b00;
      case (req)
         2'b01:   gnt_sel = 2'b01;
         2'b10:   gnt_sel = 2'b10;
         2'b11:   gnt_sel = last_gnt ? 2'b01 : 2'b10;
         default: gnt_sel = 2'b00;
      endcase
   end

   // Remember who was granted so the next tie goes the other way
   always_ff @(posedge clk_200MHz_i or posedge reset) begin
      if (reset) begin
         last_gnt <= 1'b1;
      end else if (accept) begin
         last_gnt <= gnt_sel[1];
      end
   end

endmodule

// File: rtl/adc_acq_sched.sv
// ADC acquisition scheduler: grants one of two requesters, holds the ADC in
// reset for a fixed time, enables the ADC clock while counting sample ticks
// up to the latched target, then idles for a guard period before re-arbitrating.
module adc_acq_sched
   import adc_acq_sched_pkg::*;
#(
   parameter int RST_CYCLES   = RST_CYCLES_DEF,
   parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk_200MHz_i,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [CNT_W-1:0] num_samples0,
   input  logic [CNT_W-1:0] num_samples1,
   input  logic             sample_tick,
   input  logic             abort,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             clock_to_ADC_req,
   output logic             reset_ADC_signal,
   output logic [1:0]       done,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam int DUR_W = $clog2(max2(RST_CYCLES, GUARD_CYCLES) + 1);
   localparam logic [DUR_W-1:0] RST_LAST   = DUR_W'(RST_CYCLES - 1);
   localparam logic [DUR_W-1:0] GUARD_LAST = DUR_W'(GUARD_CYCLES - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [DUR_W-1:0] dur_cnt;
   logic [CNT_W-1:0] target;
   logic [1:0]       done_nxt;
   logic             grant;
   logic [1:0]       arb_gnt;
   logic             any_req;
   logic             final_tick;

   adc_rr_arb2 u_arb (
      .clk_200MHz_i (clk_200MHz_i),
      .reset        (reset),
      .req          (req),
      .accept       (grant),
      .gnt_sel      (arb_gnt),
      .any_req      (any_req)
   );

   // Target is never 0 while in ACQ, so target-1 cannot underflow there
   assign final_tick = sample_tick && (sample_cnt == target - CNT_W'(1));

   // Next-state and completion decode
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
      state_nxt = state;
      done_nxt  = 2'b00;
      grant     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_nxt = ST_ADC_RST;
               grant     = 1'b1;
            end
         end
         ST_ADC_RST: begin
            if (abort) begin
               state_nxt = ST_GUARD;
               done_nxt  = gnt;
            end else if (dur_cnt == RST_LAST) begin
               if (target == '0) begin
                  state_nxt = ST_GUARD;
                  done_nxt  = gnt;
               end else begin
                  state_nxt = ST_ACQ;
               end
            end
         end
         ST_ACQ: begin
            if (abort || final_tick) begin
               state_nxt = ST_GUARD;
               done_nxt  = gnt;
            end
         end
         ST_GUARD: begin
            if (dur_cnt == GUARD_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Time spent in ADC_RST / GUARD; restarts on every state change
   always_ff @(posedge clk_200MHz_i or posedge reset) begin
      if (reset) begin
         dur_cnt <= '0;
      end else if (state_nxt != state) begin
         dur_cnt <= '0;
      end else if (state == ST_ADC_RST || state == ST_GUARD) begin
         dur_cnt <= dur_cnt + DUR_W'(1);
      end
   end

   // State, registered outputs, latched target and sample counter
   always_ff @(posedge clk_200MHz_i or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         gnt              <= 2'b00;
         busy             <= 1'b0;
         clock_to_ADC_req <= 1'b0;
         reset_ADC_signal <= 1'b0;
         done             <= 2'b00;
         sample_cnt       <= '0;
         target           <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state            <= state_nxt;
         busy             <= (state_nxt != ST_IDLE);
         clock_to_ADC_req <= (state_nxt == ST_ACQ);
         reset_ADC_signal <= (state_nxt == ST_ADC_RST);
         done             <= done_nxt;
         if (grant) begin
            gnt        <= arb_gnt;
            target     <= arb_gnt[1] ? num_samples1 : num_samples0;
            sample_cnt <= '0;
         end else if (state_nxt == ST_IDLE) begin
            gnt <= 2'b00;
         end
         if (state == ST_ACQ && sample_tick) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adc_acq_sched.sv
// Self-checking bench for adc_acq_sched: each expected completion is queued
// when a request is issued and checked when done pulses.
module tb_adc_acq_sched;

   localparam int CNT_W = 16;

   logic             clk_200MHz_i = 1'b0;
   logic             reset;
   logic [1:0]       req;
   logic [CNT_W-1:0] num_samples0;
   logic [CNT_W-1:0] num_samples1;
   logic             sample_tick;
   logic             abort;
   logic [1:0]       gnt;
   logic             busy;
   logic             clock_to_ADC_req;
   logic             reset_ADC_signal;
   logic [1:0]       done;
   logic [CNT_W-1:0] sample_cnt;

   typedef struct {
      logic [1:0]       who;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   adc_acq_sched dut (
      .clk_200MHz_i     (clk_200MHz_i),
      .reset            (reset),
      .req              (req),
      .num_samples0     (num_samples0),
      .num_samples1     (num_samples1),
      .sample_tick      (sample_tick),
      .abort            (abort),
      .gnt              (gnt),
      .busy             (busy),
      .clock_to_ADC_req (clock_to_ADC_req),
      .reset_ADC_signal (reset_ADC_signal),
      .done             (done),
      .sample_cnt       (sample_cnt)
   );

   always #5 clk_200MHz_i = ~clk_200MHz_i;

   // Scoreboard: every done pulse must match the oldest queued expectation
   always @(negedge clk_200MHz_i) begin
      exp_t e;
      if (!reset && done !== 2'b00) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_unexpected: done=%b, no completion expected", done);
         end else begin
            e = sb_q.pop_front();
            n_cmp++;
            if (done !== e.who) begin
               n_err++; $display("FAIL done_target: done=%b, expected %b", done, e.who);
            end
            n_cmp++;
            if (gnt !== e.who) begin
               n_err++; $display("FAIL done_gnt: gnt=%b, expected %b", gnt, e.who);
            end
            n_cmp++;
            if (sample_cnt !== e.cnt) begin
               n_err++; $display("FAIL done_cnt: sample_cnt=%0d, expected %0d", sample_cnt, e.cnt);
            end
         end
      end
   end

   // Global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_200MHz_i);
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
   endtask

   task automatic wait_acq();
      int w = 0;
      while (clock_to_ADC_req !== 1'b1 && w < 40) begin w++; step(1); end
      n_cmp++;
      if (clock_to_ADC_req !== 1'b1) begin
         n_err++; $display("FAIL acq_entry_timeout: clock_to_ADC_req=%b after %0d cycles, expected 1", clock_to_ADC_req, w);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 2'b00; num_samples0 = '0; num_samples1 = '0;
      sample_tick = 1'b0; abort = 1'b0;
      step(3);
      n_cmp++;
      if ({gnt, done, busy, clock_to_ADC_req, reset_ADC_signal} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b clk_req=%b rst_sig=%b, expected all 0",
                           gnt, done, busy, clock_to_ADC_req, reset_ADC_signal);
      end
      n_cmp++;
      if (sample_cnt !== '0) begin
         n_err++; $display("FAIL reset_cnt: sample_cnt=%0d, expected 0", sample_cnt);
      end
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_single();
      int c = 0;
      num_samples0 = 16'd3; num_samples1 = 16'd9; req = 2'b01;
      sb_q.push_back('{who: 2'b01, cnt: 16'd3});
      step(1);
      n_cmp++;
      if (gnt !== 2'b01 || reset_ADC_signal !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL single_grant: gnt=%b rst_sig=%b busy=%b, expected 01/1/1", gnt, reset_ADC_signal, busy);
      end
      // Dropped request and changed count must not affect this acquisition
      req = 2'b00; num_samples0 = 16'd7;
      while (reset_ADC_signal === 1'b1 && c < 50) begin c++; step(1); end
      n_cmp++;
      if (c != 8) begin
         n_err++; $display("FAIL single_rst_len: reset_ADC_signal high %0d cycles, expected 8", c);
      end
      n_cmp++;
      if (clock_to_ADC_req !== 1'b1) begin
         n_err++; $display("FAIL single_acq: clock_to_ADC_req=%b, expected 1", clock_to_ADC_req);
      end
      for (int i = 0; i < 2; i++) begin step(2); tick(); end
      n_cmp++;
      if (clock_to_ADC_req !== 1'b1 || sample_cnt !== 16'd2) begin
         n_err++; $display("FAIL single_mid: clk_req=%b sample_cnt=%0d, expected 1/2", clock_to_ADC_req, sample_cnt);
      end
      step(2); tick();
      n_cmp++;
      if (clock_to_ADC_req !== 1'b0 || sample_cnt !== 16'd3) begin
         n_err++; $display("FAIL single_end: clk_req=%b sample_cnt=%0d, expected 0/3", clock_to_ADC_req, sample_cnt);
      end
      c = 0;
      while (gnt !== 2'b00 && c < 50) begin c++; step(1); end
      n_cmp++;
      if (c != 4) begin
         n_err++; $display("FAIL single_guard: guard lasted %0d cycles, expected 4", c);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL single_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_seq [3];
      int w;
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
      #2 reset = 1'b1;
      step(2);
      reset = 1'b0;
      num_samples0 = 16'd1; num_samples1 = 16'd1; req = 2'b11; sample_tick = 1'b1;
      for (int r = 0; r < 3; r++) sb_q.push_back('{who: exp_seq[r], cnt: 16'd1});
      for (int r = 0; r < 3; r++) begin
         w = 0;
         while (gnt === 2'b00 && w < 50) begin w++; step(1); end
         n_cmp++;
         if (gnt !== exp_seq[r]) begin
            n_err++; $display("FAIL b2b_grant%0d: gnt=%b, expected %b", r, gnt, exp_seq[r]);
         end
         if (r == 2) req = 2'b00;
         w = 0;
         while (done === 2'b00 && w < 50) begin w++; step(1); end
         w = 0;
         while (gnt !== 2'b00 && w < 50) begin w++; step(1); end
         n_cmp++;
         if (w != 4) begin
            n_err++; $display("FAIL b2b_guard%0d: guard lasted %0d cycles, expected 4", r, w);
         end
      end
      sample_tick = 1'b0;
      step(2);
   endtask

   task automatic test_zero_target();
      int  w = 0;
      logic rose = 1'b0;
      num_samples1 = 16'd0; req = 2'b10;
      sb_q.push_back('{who: 2'b10, cnt: 16'd0});
      step(1);
      n_cmp++;
      if (gnt !== 2'b10) begin
         n_err++; $display("FAIL zero_grant: gnt=%b, expected 10", gnt);
      end
      req = 2'b00;
      while (busy === 1'b1 && w < 60) begin
         if (clock_to_ADC_req !== 1'b0) rose = 1'b1;
         w++; step(1);
      end
      n_cmp++;
      if (rose !== 1'b0) begin
         n_err++; $display("FAIL zero_clk: clock_to_ADC_req rose=%b, expected 0", rose);
      end
      n_cmp++;
      if (w != 12) begin
         n_err++; $display("FAIL zero_busy_len: busy %0d cycles, expected 12", w);
      end
      step(1);
   endtask

   task automatic test_abort();
      int g = 0;
      num_samples0 = 16'd5; req = 2'b01;
      sb_q.push_back('{who: 2'b01, cnt: 16'd2});
      step(1);
      req = 2'b00;
      wait_acq();
      step(1); tick(); step(1); tick();
      abort = 1'b1; step(1); abort = 1'b0;
      n_cmp++;
      if (clock_to_ADC_req !== 1'b0 || sample_cnt !== 16'd2 || busy !== 1'b1) begin
         n_err++; $display("FAIL abort_state: clk_req=%b sample_cnt=%0d busy=%b, expected 0/2/1",
                           clock_to_ADC_req, sample_cnt, busy);
      end
      // abort during GUARD must not shorten or restart it
      while (gnt !== 2'b00 && g < 50) begin abort = (g == 1); g++; step(1); end
      abort = 1'b0;
      n_cmp++;
      if (g != 4) begin
         n_err++; $display("FAIL abort_guard: guard lasted %0d cycles, expected 4", g);
      end
      // abort in IDLE with no request does nothing
      abort = 1'b1; step(2); abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || gnt !== 2'b00) begin
         n_err++; $display("FAIL abort_idle: busy=%b gnt=%b, expected 0/00", busy, gnt);
      end
   endtask

   task automatic test_abort_final_tick();
      num_samples1 = 16'd2; req = 2'b10;
      sb_q.push_back('{who: 2'b10, cnt: 16'd2});
      step(1);
      req = 2'b00;
      wait_acq();
      step(1); tick(); step(1);
      sample_tick = 1'b1; abort = 1'b1;
      step(1);
      sample_tick = 1'b0; abort = 1'b0;
      n_cmp++;
      if (sample_cnt !== 16'd2 || clock_to_ADC_req !== 1'b0) begin
         n_err++; $display("FAIL abort_final: sample_cnt=%0d clk_req=%b, expected 2/0", sample_cnt, clock_to_ADC_req);
      end
      step(6);
   endtask

   task automatic test_reset_mid_acq();
      num_samples0 = 16'd5; req = 2'b01;
      step(1);
      wait_acq();
      tick(); step(1);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, done, busy, clock_to_ADC_req, reset_ADC_signal} !== 7'b0 || sample_cnt !== '0) begin
         n_err++; $display("FAIL midreset_async: gnt=%b done=%b busy=%b clk_req=%b rst_sig=%b cnt=%0d, expected all 0",
                           gnt, done, busy, clock_to_ADC_req, reset_ADC_signal, sample_cnt);
      end
      req = 2'b10; num_samples1 = 16'd1;
      step(2);
      reset = 1'b0;
      sb_q.push_back('{who: 2'b10, cnt: 16'd1});
      step(1);
      n_cmp++;
      if (gnt !== 2'b10) begin
         n_err++; $display("FAIL midreset_regrant: gnt=%b, expected 10", gnt);
      end
      req = 2'b00;
      wait_acq();
      tick();
      step(6);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_target();
      test_abort();
      test_abort_final_tick();
      test_reset_mid_acq();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: %0d completions never seen, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_acq_sched.md
ADC_ACQ_SCHED -- requirements
Module: adc_acq_sched

Interface
REQ-001 Parameter RST_CYCLES, default 8: number of clock cycles reset_ADC_signal is held high before each acquisition.
REQ-002 Parameter GUARD_CYCLES, default 4: idle cycles after an acquisition before the next grant.
REQ-003 Parameter CNT_W, default 16: width of the sample-count fields.
REQ-004 Clock and reset: one clock, clk_200MHz_i; reset is asynchronous and active-high, named reset.
REQ-005 clk_200MHz_i  in  1  system clock; all logic runs on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  2  acquisition request, one bit per requester; level, held until done.
REQ-008 num_samples0  in  CNT_W  samples wanted by requester 0; sampled at grant.
REQ-009 num_samples1  in  CNT_W  samples wanted by requester 1; sampled at grant.
REQ-010 sample_tick  in  1  one-cycle strobe per 5 MHz ADC period, synchronous to clk_200MHz_i.
REQ-011 abort  in  1  terminate the current acquisition.
REQ-012 gnt  out  2  one-hot grant; high from grant through the end of GUARD.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 clock_to_ADC_req  out  1  ADC clock enable; high only in ACQ.
REQ-015 reset_ADC_signal  out  1  ADC reset; high only in ADC_RST.
REQ-016 done  out  2  one-cycle pulse to the granted requester on completion or abort.
REQ-017 sample_cnt  out  CNT_W  samples taken in the current acquisition.

Function
REQ-018 FSM states: IDLE, ADC_RST, ACQ, GUARD; all outputs registered.
REQ-019 IDLE -> ADC_RST when any req bit is high; the grant is fixed at that edge and the target count is latched from the winner's num_samples.
REQ-020 Arbitration is round-robin: a last_gnt flag selects the other requester on a tie; after reset, requester 0 has priority.
REQ-021 ADC_RST lasts exactly RST_CYCLES cycles, then -> ACQ; sample_tick is ignored in ADC_RST.
REQ-022 In ACQ, each sample_tick increments sample_cnt by 1.
REQ-023 ACQ -> GUARD on the cycle after the tick that makes sample_cnt equal the target; done[granted] pulses on that same transition edge.
REQ-024 A latched target of 0 skips ACQ: ADC_RST -> GUARD, and done pulses.
REQ-025 abort in ADC_RST or ACQ -> GUARD on the next edge; done pulses and sample_cnt holds its value; abort in IDLE or GUARD has no effect.
REQ-026 GUARD lasts exactly GUARD_CYCLES cycles; gnt clears on GUARD -> IDLE.
REQ-027 A requester dropping req mid-operation does not stop the acquisition; only abort does.
REQ-028 sample_cnt clears on IDLE -> ADC_RST and never wraps; the target is at most 2^CNT_W-1.
REQ-029 A req change to num_samples after grant has no effect on the current acquisition.
REQ-030 If abort and the final sample_tick arrive in the same cycle, the sample counts and a single done pulse is issued.

Reset
REQ-031 On reset (asynchronous assertion): state IDLE; gnt=0, busy=0, clock_to_ADC_req=0, reset_ADC_signal=0, done=0, sample_cnt=0, last_gnt selects requester 1 so that requester 0 wins first.
REQ-032 Reset asserted mid-acquisition drops clock_to_ADC_req immediately, and no done pulse is issued.
REQ-033 Reset is released synchronously to clk_200MHz_i.

Structure
REQ-034 A shared package holds the FSM state encoding and the default values of RST_CYCLES, GUARD_CYCLES and CNT_W.
REQ-035 A single sub-module, adc_rr_arb2, implements the 2-way round-robin arbiter; the duration counters and sample counter stay in the top-level module.

Verification
REQ-036 req=01, num_samples0=3, three ticks -> reset_ADC_signal high 8 cycles, clock_to_ADC_req high until the third tick, done=01 once, sample_cnt=3.
REQ-037 req=11 held through two rounds -> grant sequence 01, 10, 01; a 4-cycle guard appears between grants.
REQ-038 num_samples1=0 -> ADC_RST then GUARD; clock_to_ADC_req never rises; done=10 pulses.
REQ-039 abort after 2 of 5 ticks -> GUARD next cycle, sample_cnt=2, single done pulse.
REQ-040 reset asserted during ACQ -> all outputs 0 asynchronously, no done; after release, a pending req=10 is granted first to requester 0 only if req0 is also high.
REQ-041 abort coincident with the final tick -> sample_cnt equals the target, exactly one done pulse.
